// File: rtl/irq_unit_if.sv
// irq_unit_if: single-beat data-bus connection between a bus master and the
// irq_unit register block.
//
// Signals:
//   req    master -> slave  request, held until ack
//   we     master -> slave  1 = write, 0 = read
//   addr   master -> slave  byte offset (bits [1:0] ignored by the slave)
//   wdata  master -> slave  write data
//   rdata  slave -> master  read data, valid with ack and held until next ack
//   ack    slave -> master  single-cycle completion pulse
interface irq_unit_if;
  logic        req;
  logic        we;
  logic [5:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;

  modport master (
    output req, we, addr, wdata,
    input  rdata, ack
  );

  modport slave (
    input  req, we, addr, wdata,
    output rdata, ack
  );
endinterface

// File: rtl/irq_unit.sv
// irq_unit: machine-level interrupt sources for the CSR unit.
//   - 64-bit mtime/mtimecmp timer driving MTIP (ip[7])
//   - software interrupt register driving MSIP (ip[3])
//   - edge-triggered external interrupt gateway with pending/enable/claim
//     registers driving MEIP (ip[11])
//
// Ports:
//   clk      core clock
//   rst      asynchronous, active-low reset
//   ext_irq  N_EXT asynchronous external interrupt lines
//   bus      irq_unit_if.slave register bus (req/we/addr/wdata/rdata/ack)
//   ip       32-bit pending vector: bit3 MSIP, bit7 MTIP, bit11 MEIP
//
// Register map (word offsets on addr[5:2]):
//   0x00 MSIP  0x04 mtime lo  0x08 mtime hi  0x0C mtimecmp lo
//   0x10 mtimecmp hi  0x14 PEND (W1C)  0x18 EN  0x1C CLAIM (read clears)
//   0x20 MODE (only with IRQ_LEVEL_EN)
//
// Optional feature: define IRQ_LEVEL_EN to add the MODE register, which makes
// selected lines level-sensitive. Without it every line is edge-triggered and
// 0x20 behaves as an unmapped offset.
module irq_unit #(
  parameter int N_EXT       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_EXT-1:0] ext_irq,
  irq_unit_if.slave        bus,
  output logic [31:0]      ip
);

  logic        access;
  logic        wr;
  logic        rd;
  logic [3:0]  off;
  logic        unused_addr;

  logic        ack_q;
  logic [31:0] rdata_q;
  logic [31:0] rd_val;

  logic [63:0] mtime;
  logic [63:0] mtimecmp;
  logic        msip;
  logic        mtip_q;
  logic        meip_q;

  logic [SYNC_STAGES-1:0][N_EXT-1:0] sync_q;
  logic [N_EXT-1:0] sync_out;
  logic [N_EXT-1:0] hist;
  logic [N_EXT-1:0] rise;
  logic [N_EXT-1:0] pend;
  logic [N_EXT-1:0] pend_nxt;
  logic [N_EXT-1:0] en;
  logic [N_EXT-1:0] claim_sel;
  logic [4:0]       claim_id;
  logic             claim_hit;
  logic             claim_clr;
`ifdef IRQ_LEVEL_EN
  logic [N_EXT-1:0] mode;
`endif

  // A request is sampled only while ack is low, so a held request completes
  // every second cycle.
  assign access      = bus.req & ~ack_q;
  assign wr          = access & bus.we;
  assign rd          = access & ~bus.we;
  assign off         = bus.addr[5:2];
  assign unused_addr = ^bus.addr[1:0];

  assign bus.ack   = ack_q;
  assign bus.rdata = rdata_q;

  assign ip = {20'b0, meip_q, 3'b0, mtip_q, 3'b0, msip, 3'b0};

  // Synchronizer chain and edge history for the external lines.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
      hist   <= '0;
    end else begin
      sync_q[0] <= ext_irq;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
      hist <= sync_out;
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign rise     = sync_out & ~hist;

  // Lowest-numbered enabled pending line wins the claim; the loop runs
  // downward so the last match is the lowest index.
  always_comb begin
    claim_hit = 1'b0;
    claim_id  = '0;
    claim_sel = '0;
    for (int i = N_EXT - 1; i >= 0; i--) begin
      if (pend[i] && en[i]) begin
        claim_hit    = 1'b1;
        claim_id     = 5'(i);
        claim_sel    = '0;
        claim_sel[i] = 1'b1;
      end
    end
  end

  assign claim_clr = rd && (off == 4'd7) && claim_hit;

  // Clears are applied before the new edge so a coincident edge wins.
  always_comb begin
    pend_nxt = pend;
    if (wr && (off == 4'd5)) begin
      pend_nxt = pend_nxt & ~bus.wdata[N_EXT-1:0];
    end
    if (claim_clr) begin
      pend_nxt = pend_nxt & ~claim_sel;
    end
    pend_nxt = pend_nxt | rise;
`ifdef IRQ_LEVEL_EN
    pend_nxt = (pend_nxt & ~mode) | (sync_out & mode);
`endif
  end

  // Read multiplexer.
  always_comb begin
    rd_val = '0;
    case (off)
      4'd0: rd_val = {31'b0, msip};
      4'd1: rd_val = mtime[31:0];
      4'd2: rd_val = mtime[63:32];
      4'd3: rd_val = mtimecmp[31:0];
      4'd4: rd_val = mtimecmp[63:32];
      4'd5: rd_val = {{(32-N_EXT){1'b0}}, pend};
      4'd6: rd_val = {{(32-N_EXT){1'b0}}, en};
      4'd7: rd_val = claim_hit ? ({27'b0, claim_id} + 32'd1) : 32'd0;
`ifdef IRQ_LEVEL_EN
      4'd8: rd_val = {{(32-N_EXT){1'b0}}, mode};
`endif
      default: rd_val = '0;
    endcase
  end

  // Bus response: ack one cycle after the sampled request, rdata loaded with it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ack_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      ack_q <= access;
      if (access) begin
        rdata_q <= rd_val;
      end
    end
  end

  // Timer: a half-word write replaces that half and suppresses the increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mtime    <= '0;
      mtimecmp <= '1;
      mtip_q   <= 1'b0;
    end else begin
      if (wr && (off == 4'd1)) begin
        mtime[31:0] <= bus.wdata;
      end else if (wr && (off == 4'd2)) begin
        mtime[63:32] <= bus.wdata;
      end else begin
        mtime <= mtime + 64'd1;
      end
      if (wr && (off == 4'd3)) begin
        mtimecmp[31:0] <= bus.wdata;
      end
      if (wr && (off == 4'd4)) begin
        mtimecmp[63:32] <= bus.wdata;
      end
      mtip_q <= (mtime >= mtimecmp);
    end
  end

  // Software interrupt, gateway state and MEIP.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      msip   <= 1'b0;
      en     <= '0;
      pend   <= '0;
      meip_q <= 1'b0;
`ifdef IRQ_LEVEL_EN
      mode   <= '0;
`endif
    end else begin
      if (wr && (off == 4'd0)) begin
        msip <= bus.wdata[0];
      end
      if (wr && (off == 4'd6)) begin
        en <= bus.wdata[N_EXT-1:0];
      end
`ifdef IRQ_LEVEL_EN
      if (wr && (off == 4'd8)) begin
        mode <= bus.wdata[N_EXT-1:0];
      end
`endif
      pend   <= pend_nxt;
      meip_q <= |(pend & en);
    end
  end

endmodule

// File: tb/tb_irq_unit.sv
// tb_irq_unit: self-checking bench for irq_unit. Register reads push their
// expected value onto a scoreboard queue when issued; a monitor pops and
// compares on each read ack. Interrupt outputs are checked inline per test.
module tb_irq_unit;
  localparam int N_EXT = 4;
  localparam int SYNC  = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [N_EXT-1:0] ext_irq = '0;
  logic [31:0]      ip;

  irq_unit_if bus ();

  irq_unit #(.N_EXT(N_EXT), .SYNC_STAGES(SYNC)) dut (
    .clk     (clk),
    .rst     (rst),
    .ext_irq (ext_irq),
    .bus     (bus),
    .ip      (ip)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_q[$];
  string       name_q[$];
  bit          cur_rd = 1'b0;
  logic [63:0] cyc;
  logic [63:0] mtime_base = '0;
  logic [63:0] base_cyc = '0;
  logic [31:0] sb_exp;
  string       sb_name;

  // Edges since reset release; mtime is reconstructed from this.
  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= '0;
    else      cyc <= cyc + 64'd1;
  end

  function automatic logic [63:0] model_mtime();
    return mtime_base + (cyc - base_cyc);
  endfunction

  // Scoreboard monitor: compare every read completion with the queued value.
  always begin
    @(posedge clk);
    #1;
    if (rst && bus.ack && cur_rd) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_read: rdata=%h with nothing expected", bus.rdata);
      end else begin
        sb_exp  = exp_q.pop_front();
        sb_name = name_q.pop_front();
        if (bus.rdata !== sb_exp) begin
          errors++;
          $display("[TB] FAIL %s: rdata=%h expected=%h", sb_name, bus.rdata, sb_exp);
        end
      end
    end
  end

  // One bus transaction; called at a negedge with ack low, returns at a
  // negedge after ack has dropped.
  task automatic bus_xfer(input bit w, input logic [5:0] a, input logic [31:0] d,
                          output int lat, output bit ack_after);
    cur_rd    = !w;
    bus.req   = 1'b1;
    bus.we    = w;
    bus.addr  = a;
    bus.wdata = d;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!bus.ack && lat < 10);
    bus.req = 1'b0;
    if (!bus.ack) begin
      checks++;
      errors++;
      $display("[TB] FAIL bus_timeout: addr=%h no ack after %0d cycles", a, lat);
    end
    @(posedge clk);
    #1;
    ack_after = bus.ack;
    @(negedge clk);
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d);
    int l;
    bit s;
    bus_xfer(1'b1, a, d, l, s);
  endtask

  task automatic rd_exp(input logic [5:0] a, input logic [31:0] e, input string nm);
    int l;
    bit s;
    exp_q.push_back(e);
    name_q.push_back(nm);
    bus_xfer(1'b0, a, 32'd0, l, s);
  endtask

  task automatic test_reset();
    int          lat;
    bit          ack_after;
    logic [63:0] t;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (ip !== 32'd0 || bus.ack !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: ip=%h ack=%b expected ip=0 ack=0", ip, bus.ack);
    end
    rst = 1'b1;
    @(negedge clk);
    exp_q.push_back(32'hFFFF_FFFF);
    name_q.push_back("mtimecmp_hi_reset");
    bus_xfer(1'b0, 6'h10, 32'd0, lat, ack_after);
    checks++;
    if (lat !== 1) begin
      errors++;
      $display("[TB] FAIL ack_latency: cycles=%0d expected=1", lat);
    end
    checks++;
    if (ack_after !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ack_width: ack=%b one cycle later expected=0", ack_after);
    end
    t = model_mtime();
    rd_exp(6'h04, t[31:0], "mtime_lo_count");
    checks++;
    if (ip !== 32'd0) begin
      errors++;
      $display("[TB] FAIL ip_after_reset: ip=%h expected=0", ip);
    end
  endtask

  task automatic test_mtip();
    logic [63:0] t;
    logic [31:0] target;
    int n;
    wr(6'h10, 32'd0);
    t = model_mtime();
    target = t[31:0] + 32'd40;
    wr(6'h0C, target);
    checks++;
    if (ip[7] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mtip_early: ip7=%b expected=0", ip[7]);
    end
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!ip[7] && n < 200);
    checks++;
    if (ip[7] !== 1'b1 || model_mtime() !== ({32'd0, target} + 64'd1)) begin
      errors++;
      $display("[TB] FAIL mtip_rise: ip7=%b mtime=%0d expected ip7=1 at mtime=%0d",
               ip[7], model_mtime(), {32'd0, target} + 64'd1);
    end
    @(negedge clk);
    wr(6'h0C, 32'hFFFF_FFFF);
    wr(6'h10, 32'hFFFF_FFFF);
    @(negedge clk);
    checks++;
    if (ip[7] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mtip_clear: ip7=%b expected=0", ip[7]);
    end
    rd_exp(6'h0C, 32'hFFFF_FFFF, "mtimecmp_lo_readback");
  endtask

  task automatic test_msip();
    wr(6'h00, 32'h3);
    @(negedge clk);
    checks++;
    if (ip !== 32'h8) begin
      errors++;
      $display("[TB] FAIL msip_set: ip=%h expected=00000008", ip);
    end
    rd_exp(6'h00, 32'd1, "msip_read_1");
    wr(6'h00, 32'h0);
    @(negedge clk);
    checks++;
    if (ip !== 32'h0) begin
      errors++;
      $display("[TB] FAIL msip_clear: ip=%h expected=0", ip);
    end
    rd_exp(6'h00, 32'd0, "msip_read_0");
  endtask

  task automatic test_mtime_write();
    logic [63:0] pre;
    logic [63:0] t;
    pre = model_mtime();
    wr(6'h04, 32'd100);
    mtime_base = {pre[63:32], 32'd100} + 64'd1;
    base_cyc   = cyc;
    t = model_mtime();
    rd_exp(6'h04, t[31:0], "mtime_lo_write");
    pre = model_mtime();
    wr(6'h08, 32'd5);
    mtime_base = {32'd5, pre[31:0]} + 64'd1;
    base_cyc   = cyc;
    rd_exp(6'h08, 32'd5, "mtime_hi_write");
    t = model_mtime();
    rd_exp(6'h04, t[31:0], "mtime_lo_after_hi");
  endtask

  task automatic test_external();
    int n;
    wr(6'h18, 32'h6);
    rd_exp(6'h18, 32'h6, "en_readback");
    ext_irq[2] = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!ip[11] && n < 20);
    checks++;
    if (n !== SYNC + 2 || ip[11] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL meip_latency: cycles=%0d ip11=%b expected %0d cycles", n, ip[11], SYNC + 2);
    end
    @(negedge clk);
    ext_irq[2] = 1'b0;
    ext_irq[1] = 1'b1;
    repeat (3) @(negedge clk);
    ext_irq[1] = 1'b0;
    repeat (4) @(negedge clk);
    rd_exp(6'h1C, 32'd2, "claim_first");
    checks++;
    if (ip[11] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL meip_after_claim1: ip11=%b expected=1", ip[11]);
    end
    rd_exp(6'h1C, 32'd3, "claim_second");
    checks++;
    if (ip[11] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL meip_after_claim2: ip11=%b expected=0", ip[11]);
    end
    rd_exp(6'h1C, 32'd0, "claim_empty");
    rd_exp(6'h14, 32'd0, "pend_empty");
    ext_irq[0] = 1'b1;
    repeat (3) @(negedge clk);
    ext_irq[0] = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (ip[11] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL meip_disabled: ip11=%b expected=0", ip[11]);
    end
    rd_exp(6'h14, 32'd1, "pend_disabled_line");
    wr(6'h18, 32'h7);
    @(negedge clk);
    checks++;
    if (ip[11] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL meip_late_enable: ip11=%b expected=1", ip[11]);
    end
    rd_exp(6'h1C, 32'd1, "claim_line0");
    wr(6'h18, 32'h6);
    rd_exp(6'h14, 32'd0, "pend_after_claim0");
  endtask

  task automatic test_set_wins();
    ext_irq[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    wr(6'h14, 32'h1);
    rd_exp(6'h14, 32'h1, "pend_set_wins");
    wr(6'h14, 32'h1);
    repeat (100) @(negedge clk);
    rd_exp(6'h14, 32'h0, "pend_held_once");
    ext_irq[0] = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_level();
`ifdef IRQ_LEVEL_EN
    int n;
    wr(6'h20, 32'h1);
    rd_exp(6'h20, 32'h1, "mode_readback");
    wr(6'h18, 32'h1);
    ext_irq[0] = 1'b1;
    repeat (5) @(negedge clk);
    rd_exp(6'h1C, 32'd1, "claim_level_1");
    rd_exp(6'h1C, 32'd1, "claim_level_2");
    wr(6'h14, 32'h1);
    rd_exp(6'h14, 32'h1, "level_w1c_ignored");
    ext_irq[0] = 1'b0;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (ip[11] && n < 20);
    checks++;
    if (n !== SYNC + 2 || ip[11] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL level_release: cycles=%0d ip11=%b expected %0d cycles", n, ip[11], SYNC + 2);
    end
    @(negedge clk);
    wr(6'h20, 32'h0);
    wr(6'h18, 32'h6);
`else
    wr(6'h20, 32'h1);
    rd_exp(6'h20, 32'h0, "mode_unmapped");
`endif
  endtask

  task automatic test_unmapped();
    wr(6'h3C, 32'hFFFF_FFFF);
    rd_exp(6'h3C, 32'd0, "unmapped_3c");
    rd_exp(6'h24, 32'd0, "unmapped_24");
    rd_exp(6'h18, 32'h6, "en_untouched");
  endtask

  task automatic test_reset_mid();
    logic [63:0] t;
    cur_rd    = 1'b0;
    bus.req   = 1'b1;
    bus.we    = 1'b1;
    bus.addr  = 6'h00;
    bus.wdata = 32'h1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.ack !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ack_before_reset: ack=%b expected=1", bus.ack);
    end
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if (bus.ack !== 1'b0 || ip !== 32'd0) begin
      errors++;
      $display("[TB] FAIL ack_drop_on_reset: ack=%b ip=%h expected ack=0 ip=0", bus.ack, ip);
    end
    bus.req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    mtime_base = '0;
    base_cyc   = '0;
    @(negedge clk);
    rd_exp(6'h00, 32'd0, "msip_after_reset");
    rd_exp(6'h10, 32'hFFFF_FFFF, "mtimecmp_after_reset");
    t = model_mtime();
    rd_exp(6'h04, t[31:0], "mtime_after_reset");
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.req   = 1'b0;
    bus.we    = 1'b0;
    bus.addr  = '0;
    bus.wdata = '0;
    test_reset();
    test_mtip();
    test_msip();
    test_mtime_write();
    test_external();
    test_set_wins();
    test_level();
    test_unmapped();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: %0d reads outstanding expected=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
